// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard-to-direction path.
// Holds direction codes, scan codes, FSM state types and small decode helpers.
package ps2_pkg;

  localparam logic [2:0] DIR_NONE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_LEFT  = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b011;
  localparam logic [2:0] DIR_RIGHT = 3'b100;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  typedef enum logic {
    DEC_NORMAL,
    DEC_BREAK
  } dec_state_t;

  // Non-arrow codes map to DIR_NONE, which callers treat as "no change".
  function automatic logic [2:0] arrow_dir(input logic [7:0] sc);
    logic [2:0] d;
    d = DIR_NONE;
    case (sc)
      SC_UP:    d = DIR_UP;
      SC_LEFT:  d = DIR_LEFT;
      SC_DOWN:  d = DIR_DOWN;
      SC_RIGHT: d = DIR_RIGHT;
      default:  d = DIR_NONE;
    endcase
    return d;
  endfunction

  function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
    return ((a == DIR_UP)   && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN) && (b == DIR_UP))    ||
           ((a == DIR_LEFT) && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT));
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchroniser, falling-edge detect, 11-bit frame FSM, idle timeout.
// Byte/error pulse one cycle after the stop-bit fall cycle; no backpressure (the PS/2 device cannot be stalled).
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TO_W           = 13
) (
  input  logic       VGA_clk,
  input  logic       resetn,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  output logic       rx_err
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   bit_in;
  logic                   fall;

  frame_state_t state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TO_W-1:0] to_cnt;
  logic          timeout;
  logic          frame_ok;

  // Idle-high reset value keeps the first sample after reset from looking like a fall.
  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clock};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_s;
    end
  end

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign bit_in  = dat_sync[SYNC_STAGES-1];
  assign fall    = clk_prev & ~clk_s;

  // A fall in the same cycle as the limit wins over the timeout.
  assign timeout  = (state != FR_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign frame_ok = bit_in & (^{shreg, par_bit});

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      state <= FR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (fall) begin
      case (state)
        FR_IDLE:   if (!bit_in) state_nxt = FR_DATA;
        FR_DATA:   if (bit_cnt == 3'd7) state_nxt = FR_PARITY;
        FR_PARITY: state_nxt = FR_STOP;
        FR_STOP:   state_nxt = FR_IDLE;
        default:   state_nxt = FR_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = FR_IDLE;
    end
  end

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
      to_cnt  <= '0;
      rx_dat  <= 8'h00;
      rx_vld  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      rx_err <= 1'b0;

      if (fall || (state == FR_IDLE)) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (fall) begin
        case (state)
          FR_IDLE: bit_cnt <= 3'd0;
          FR_DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          FR_PARITY: par_bit <= bit_in;
          FR_STOP: begin
            if (frame_ok) begin
              rx_dat <= shreg;
              rx_vld <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
          end
          default: bit_cnt <= 3'd0;
        endcase
      end else if (timeout) begin
        rx_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard to snake direction: frame receive, E0/F0 prefix handling, held direction register.
// direction updates one cycle after scan_valid; no backpressure. NO_REVERSE_EN blocks direct reversals.
module ps2_direction_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TO_W           = 13
) (
  input  logic       VGA_clk,
  input  logic       resetn,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error,
  output logic [2:0] direction
);

  logic [7:0] rx_dat;
  logic       rx_vld;
  logic       rx_err;

  dec_state_t dec_state, dec_nxt;
  logic       ext, ext_nxt;
  logic [2:0] dir_nxt;
  logic [2:0] arrow;
  logic       load;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_rx (
    .VGA_clk  (VGA_clk),
    .resetn   (resetn),
    .ps2_clock(ps2_clock),
    .ps2_data (ps2_data),
    .rx_dat   (rx_dat),
    .rx_vld   (rx_vld),
    .rx_err   (rx_err)
  );

  assign scan_code   = rx_dat;
  assign scan_valid  = rx_vld;
  assign frame_error = rx_err;

  assign arrow = arrow_dir(rx_dat);
`ifdef NO_REVERSE_EN
  assign load = (arrow != DIR_NONE) && !is_opposite(direction, arrow);
`else
  assign load = (arrow != DIR_NONE);
`endif

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      dec_state <= DEC_NORMAL;
      ext       <= 1'b0;
      direction <= DIR_NONE;
    end else begin
      dec_state <= dec_nxt;
      ext       <= ext_nxt;
      direction <= dir_nxt;
    end
  end

  // Frame errors never reach here, so a break survives a corrupted release byte.
  always_comb begin
    dec_nxt = dec_state;
    ext_nxt = ext;
    dir_nxt = direction;
    if (rx_vld) begin
      if (dec_state == DEC_BREAK) begin
        dec_nxt = DEC_NORMAL;
        ext_nxt = 1'b0;
      end else if (rx_dat == SC_EXT) begin
        ext_nxt = 1'b1;
      end else if (rx_dat == SC_BREAK) begin
        dec_nxt = DEC_BREAK;
      end else begin
        ext_nxt = 1'b0;
        if (load) dir_nxt = arrow;
      end
    end
  end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Self-checking bench: directed frame table, timeout/reset sequences, randomized frames vs key model.
module tb_ps2_direction_decoder;

  localparam int TIMEOUT = 5000;
  localparam int SYNC    = 2;
  localparam int SLOW_H  = 1000;  // 12.5 kHz PS/2 clock half-period at 25 MHz

  logic       VGA_clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_error;
  logic [2:0] direction;

  ps2_direction_decoder #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TO_W          (13)
  ) dut (
    .VGA_clk    (VGA_clk),
    .resetn     (resetn),
    .ps2_clock  (ps2_clock),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_error(frame_error),
    .direction  (direction)
  );

  always #20 VGA_clk = ~VGA_clk;

  int cyc = 0;
  always @(posedge VGA_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Key model: what a player pressed, in terms of whole bytes.
  logic [7:0] exp_q[$];
  int         exp_err = 0;
  int         seen_err = 0;
  int         seen_vld = 0;
  int         overlap_cnt = 0;
  int         unexpected_cnt = 0;
  int         last_vld_cyc = 0;
  int         last_err_cyc = 0;
  logic [2:0] mdl_dir = 3'd0;
  bit         mdl_brk = 1'b0;
  bit         dir_pending = 1'b0;

  function automatic logic [2:0] key_dir(input logic [7:0] b);
    if (b == 8'h75) return 3'd1;
    if (b == 8'h6B) return 3'd2;
    if (b == 8'h72) return 3'd3;
    if (b == 8'h74) return 3'd4;
    return 3'd0;
  endfunction

  function automatic bit reverses(input logic [2:0] cur, input logic [2:0] nw);
    return (cur == 3'd1 && nw == 3'd3) || (cur == 3'd3 && nw == 3'd1) ||
           (cur == 3'd2 && nw == 3'd4) || (cur == 3'd4 && nw == 3'd2);
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [2:0] k;
    k = key_dir(b);
    if (mdl_brk) mdl_brk = 1'b0;
    else if (b == 8'hF0) mdl_brk = 1'b1;
    else if (b != 8'hE0 && k != 3'd0) begin
`ifdef NO_REVERSE_EN
      if (!reverses(mdl_dir, k)) mdl_dir = k;
`else
      mdl_dir = k;
`endif
    end
  endtask

  always @(negedge VGA_clk) begin
    logic [7:0] b;
    if (!resetn) begin
      mdl_dir = 3'd0;
      mdl_brk = 1'b0;
      dir_pending = 1'b0;
    end else begin
      if (dir_pending) begin
        check("dir_one_cycle_after_valid", direction, mdl_dir);
        dir_pending = 1'b0;
      end
      if (scan_valid && frame_error) overlap_cnt++;
      if (scan_valid) begin
        seen_vld++;
        last_vld_cyc = cyc;
        check("dir_unchanged_at_valid", direction, mdl_dir);
        if (exp_q.size() == 0) unexpected_cnt++;
        else begin
          b = exp_q.pop_front();
          check("scan_code", scan_code, b);
          model_byte(b);
          dir_pending = 1'b1;
        end
      end
      if (frame_error) begin
        seen_err++;
        last_err_cyc = cyc;
      end
    end
  end

  task automatic ps2_bit(input logic b, input int h, output int fall_cyc);
    @(negedge VGA_clk);
    ps2_data = b;
    repeat (h) @(negedge VGA_clk);
    ps2_clock = 1'b0;
    fall_cyc = cyc;
    repeat (h) @(negedge VGA_clk);
    ps2_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int h, output int stop_cyc);
    logic p;
    int   fc;
    p = ~(^b) ^ bad_par;
    if (!bad_par && !bad_stop) exp_q.push_back(b);
    else exp_err++;
    ps2_bit(1'b0, h, fc);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], h, fc);
    ps2_bit(p, h, fc);
    ps2_bit(!bad_stop, h, stop_cyc);
    ps2_data = 1'b1;
    repeat (h + 6) @(negedge VGA_clk);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    logic [2:0] exp_dir;
  } vec_t;

  vec_t vt[18];

  initial begin
    int         sc;
    int         fc;
    int         v0;
    int         e0;
    logic [2:0] d72;
    logic [2:0] d6b;
    logic [7:0] rb;
    logic [7:0] part;
    int         kind;

`ifdef NO_REVERSE_EN
    d72 = 3'd1;
    d6b = 3'd4;
`else
    d72 = 3'd3;
    d6b = 3'd2;
`endif
    vt[0]  = '{8'hE0, 1'b0, 1'b0, 3'd1};
    vt[1]  = '{8'h6B, 1'b0, 1'b0, 3'd2};
    vt[2]  = '{8'hE0, 1'b0, 1'b0, 3'd2};
    vt[3]  = '{8'hF0, 1'b0, 1'b0, 3'd2};
    vt[4]  = '{8'h6B, 1'b0, 1'b0, 3'd2};
    vt[5]  = '{8'h75, 1'b0, 1'b0, 3'd1};
    vt[6]  = '{8'h72, 1'b1, 1'b0, 3'd1};
    vt[7]  = '{8'h74, 1'b0, 1'b0, 3'd4};
    vt[8]  = '{8'h12, 1'b0, 1'b0, 3'd4};
    vt[9]  = '{8'h6B, 1'b0, 1'b1, 3'd4};
    vt[10] = '{8'hF0, 1'b0, 1'b0, 3'd4};
    vt[11] = '{8'h75, 1'b1, 1'b0, 3'd4};
    vt[12] = '{8'h72, 1'b0, 1'b0, 3'd4};
    vt[13] = '{8'h75, 1'b0, 1'b0, 3'd1};
    vt[14] = '{8'h72, 1'b0, 1'b0, d72};
    vt[15] = '{8'h74, 1'b0, 1'b0, 3'd4};
    vt[16] = '{8'h6B, 1'b0, 1'b0, d6b};
    vt[17] = '{8'h75, 1'b0, 1'b0, 3'd1};

    // Reset state
    repeat (3) @(negedge VGA_clk);
    check("reset_scan_code", scan_code, 8'h00);
    check("reset_scan_valid", scan_valid, 0);
    check("reset_frame_error", frame_error, 0);
    check("reset_direction", direction, 3'd0);
    resetn = 1'b1;
    repeat (5) @(negedge VGA_clk);

    // Slow 75 frame with exact delivery latency
    send_frame(8'h75, 1'b0, 1'b0, SLOW_H, sc);
    check("slow75_valid_count", seen_vld, 1);
    check("slow75_valid_latency", last_vld_cyc - sc, SYNC + 1);
    check("slow75_direction", direction, 3'd1);

    // Directed table
    for (int i = 0; i < 18; i++) begin
      send_frame(vt[i].code, vt[i].bad_par, vt[i].bad_stop, 12, sc);
      check($sformatf("vec%0d_direction", i), direction, vt[i].exp_dir);
      check($sformatf("vec%0d_error_count", i), seen_err, exp_err);
      if (i == 4) check("ext_break_valid_pulses", seen_vld - 1, 5);
    end

    // Partial frame then silence: timeout abort
    e0 = seen_err;
    v0 = seen_vld;
    part = 8'h0D;
    ps2_bit(1'b0, 12, fc);
    for (int i = 0; i < 4; i++) ps2_bit(part[i], 12, fc);
    ps2_data = 1'b1;
    exp_err++;
    repeat (TIMEOUT + 100) @(negedge VGA_clk);
    check("timeout_error_pulses", seen_err - e0, 1);
    check_range("timeout_latency", last_err_cyc - fc, TIMEOUT, TIMEOUT + SYNC + 6);
    check("timeout_no_valid", seen_vld - v0, 0);
    send_frame(8'h6B, 1'b0, 1'b0, 12, sc);
    check("after_timeout_direction", direction, 3'd2);

    // Reset during data bit 5
    rb = 8'h74;
    ps2_bit(1'b0, 12, fc);
    for (int i = 0; i < 5; i++) ps2_bit(rb[i], 12, fc);
    @(negedge VGA_clk);
    ps2_data = rb[5];
    repeat (12) @(negedge VGA_clk);
    ps2_clock = 1'b0;
    repeat (2) @(negedge VGA_clk);
    resetn = 1'b0;
    repeat (3) @(negedge VGA_clk);
    check("midreset_scan_code", scan_code, 8'h00);
    check("midreset_scan_valid", scan_valid, 0);
    check("midreset_frame_error", frame_error, 0);
    check("midreset_direction", direction, 3'd0);
    ps2_clock = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge VGA_clk);
    resetn = 1'b1;
    repeat (10) @(negedge VGA_clk);
    e0 = seen_err;
    v0 = seen_vld;
    send_frame(8'h74, 1'b0, 1'b0, 12, sc);
    check("postreset_direction", direction, 3'd4);
    check("postreset_valid_pulses", seen_vld - v0, 1);
    check("postreset_no_error", seen_err - e0, 0);

    // Randomized frames against the key model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 6))
        0: rb = 8'h75;
        1: rb = 8'h6B;
        2: rb = 8'h72;
        3: rb = 8'h74;
        4: rb = 8'hE0;
        5: rb = 8'hF0;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      kind = $urandom_range(0, 7);
      send_frame(rb, kind == 0, kind == 1, $urandom_range(6, 20), sc);
      repeat ($urandom_range(0, 30)) @(negedge VGA_clk);
      check("rand_direction", direction, mdl_dir);
    end

    repeat (10) @(negedge VGA_clk);
    check("final_error_count", seen_err, exp_err);
    check("final_pending_bytes", exp_q.size(), 0);
    check("unexpected_valids", unexpected_cnt, 0);
    check("valid_error_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
